bm_seq_ctrl: RTL and testbench

Issue-side sequencer for the bitmanip functional unit. It accepts one bitmanip operation at a time through a valid/ready handshake and classifies it by unit select. Single-cycle operations (bit count, shifter, simple, bextdep) return their result after one cycle. Carry-less multiply and CRC operations are stepped through a shared iterative engine with a per-operation iteration count. Results and transaction IDs are returned through a one-entry output buffer with backpressure, and a flush input kills in-flight work.

---
 rtl/bm_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_bm_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bm_seq_ctrl.sv
// Issue-side sequencer for the bitmanip unit: single-cycle results go straight to a one-entry
// output buffer; CLMUL/CRC are stepped through a shared iterative engine before capture.
module bm_seq_ctrl #(
   parameter int unsigned XLEN           = 64,
   parameter int unsigned BITS_PER_CYCLE = 8,
   parameter int unsigned TRANS_ID_BITS  = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [1:0]               req_unit_i,
   input  logic [8:0]               req_func_i,
   input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
   input  logic [XLEN-1:0]          sc_result_i,
   output logic                     eng_start_o,
   output logic                     eng_step_o,
   output logic                     eng_last_o,
   output logic [6:0]               eng_iter_o,
   output logic                     eng_kill_o,
   input  logic [XLEN-1:0]          eng_result_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [XLEN-1:0]          res_data_o,
   output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
   output logic                     busy_o
);

   localparam int unsigned BpcShift = $clog2(BITS_PER_CYCLE);

   typedef enum logic [1:0] {StIdle, StRun, StCapt} state_e;

   state_e                   state_q;
   logic [6:0]               cnt_q;
   logic [6:0]               n_q;
   logic [TRANS_ID_BITS-1:0] id_q;
   logic                     res_valid_q;
   logic [XLEN-1:0]          res_data_q;
   logic [TRANS_ID_BITS-1:0] res_id_q;

   logic       accept;
   logic       accept_mc;
   logic       drain;
   logic       in_run;
   logic       last;
   logic [7:0] width;
   logic [6:0] n_req;
   logic       unused_func;

   // Only the low function bits select the operand width.
   assign unused_func = ^req_func_i[8:2];

   always_comb begin
      width = 8'd8;
      if (req_unit_i == 2'd1) begin
         width = req_func_i[0] ? 8'd32 : 8'(XLEN);
      end else begin
         width = 8'd8 << req_func_i[1:0];
         if (width > 8'(XLEN)) begin
            width = 8'(XLEN);
         end
      end
      n_req = 7'(width >> BpcShift);
      if (n_req == 7'd0) begin
         n_req = 7'd1;
      end
   end

   assign req_ready_o = !rst_i && !flush_i && (state_q == StIdle) &&
                        (!res_valid_q || res_ready_i);
   assign accept      = req_valid_i && req_ready_o;
   assign accept_mc   = accept && ((req_unit_i == 2'd1) || (req_unit_i == 2'd2));
   assign drain       = res_valid_q && res_ready_i;
   assign in_run      = (state_q == StRun);
   assign last        = (cnt_q == n_q - 7'd1);

   assign eng_start_o = accept_mc;
   assign eng_step_o  = in_run && !flush_i && !rst_i;
   assign eng_last_o  = eng_step_o && last;
   assign eng_iter_o  = in_run ? cnt_q : 7'd0;
   assign eng_kill_o  = !rst_i && flush_i && (state_q != StIdle);

   assign res_valid_o    = res_valid_q;
   assign res_data_o     = res_data_q;
   assign res_trans_id_o = res_id_q;
   assign busy_o         = (state_q != StIdle) || res_valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= 7'd0;
         n_q         <= 7'd1;
         id_q        <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
      end else if (flush_i) begin
         state_q     <= StIdle;
         cnt_q       <= 7'd0;
         res_valid_q <= 1'b0;
      end else begin
         // A refill below overrides the drain when both happen in one cycle.
         if (drain) begin
            res_valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (accept_mc) begin
                  state_q <= StRun;
                  cnt_q   <= 7'd0;
                  n_q     <= n_req;
                  id_q    <= req_trans_id_i;
               end else if (accept) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= (req_unit_i == 2'd0) ? sc_result_i : '0;
                  res_id_q    <= req_trans_id_i;
               end
            end
            StRun: begin
               if (last) begin
                  state_q <= StCapt;
                  cnt_q   <= 7'd0;
               end else begin
                  cnt_q <= cnt_q + 7'd1;
               end
            end
            StCapt: begin
               res_valid_q <= 1'b1;
               res_data_q  <= eng_result_i;
               res_id_q    <= id_q;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bm_seq_ctrl.sv
// Bench for bm_seq_ctrl: directed scenarios then random traffic, all checked against a
// transaction-timing model (accept time, step count, buffer contents).
module tb_bm_seq_ctrl;

   localparam int XLEN = 64;
   localparam int BPC  = 8;
   localparam int IDW  = 3;

   logic            clk = 1'b0;
   logic            rst, flush, req_valid, res_ready;
   logic [1:0]      req_unit;
   logic [8:0]      req_func;
   logic [IDW-1:0]  req_id;
   logic [XLEN-1:0] sc_result, eng_result;
   logic            req_ready, eng_start, eng_step, eng_last, eng_kill;
   logic [6:0]      eng_iter;
   logic            res_valid, busy;
   logic [XLEN-1:0] res_data;
   logic [IDW-1:0]  res_id;

   bm_seq_ctrl #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .TRANS_ID_BITS(IDW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_unit_i(req_unit),
      .req_func_i(req_func), .req_trans_id_i(req_id), .sc_result_i(sc_result),
      .eng_start_o(eng_start), .eng_step_o(eng_step), .eng_last_o(eng_last),
      .eng_iter_o(eng_iter), .eng_kill_o(eng_kill), .eng_result_i(eng_result),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .res_trans_id_o(res_id), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: an in-flight multi-cycle op is described only by its accept time and step count.
   bit              mc_active;
   int              mc_acc_cyc, mc_n;
   logic [IDW-1:0]  mc_id;
   logic [XLEN-1:0] mc_res;
   bit              m_valid, m_zero;
   logic [XLEN-1:0] m_data;
   logic [IDW-1:0]  m_id;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int n_of(input logic [1:0] unit, input logic [8:0] func);
      int width;
      if (unit == 2'd1) width = func[0] ? 32 : XLEN;
      else if (XLEN == 32 && func[1:0] == 2'd3) width = XLEN;
      else width = 8 * (2 ** int'(func[1:0]));
      return (width / BPC < 1) ? 1 : width / BPC;
   endfunction

   // One clock cycle: inputs already set by the caller; check, then advance the model.
   task automatic step();
      int k;
      bit run, capt, acc, mc_acc, exp_ready;
      k    = cyc - mc_acc_cyc;
      run  = mc_active && k >= 1 && k <= mc_n;
      capt = mc_active && k == mc_n + 1;
      eng_result = capt ? mc_res : {$urandom, $urandom};
      #1;
      exp_ready = !rst && !flush && !mc_active && (!m_valid || res_ready);
      acc       = req_valid && exp_ready;
      mc_acc    = acc && (req_unit == 2'd1 || req_unit == 2'd2);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("res_valid", 64'(res_valid), 64'(m_valid));
      if (m_valid || m_zero) begin
         check("res_data", 64'(res_data), 64'(m_data));
         check("res_id", 64'(res_id), 64'(m_id));
      end
      check("busy", 64'(busy), 64'(mc_active || m_valid));
      check("eng_start", 64'(eng_start), 64'(mc_acc));
      check("eng_iter", 64'(eng_iter), run ? 64'(k - 1) : 64'd0);
      if (!rst) begin
         check("eng_step", 64'(eng_step), 64'(run && !flush));
         check("eng_last", 64'(eng_last), 64'(run && !flush && k == mc_n));
         check("eng_kill", 64'(eng_kill), 64'(flush && mc_active));
      end
      @(posedge clk);
      if (rst) begin
         mc_active = 0; m_valid = 0; m_data = '0; m_id = '0; m_zero = 1;
      end else if (flush) begin
         mc_active = 0; m_valid = 0;
      end else begin
         if (m_valid && res_ready) m_valid = 0;
         if (acc && !mc_acc) begin
            m_valid = 1; m_zero = 0; m_id = req_id;
            m_data  = (req_unit == 2'd0) ? sc_result : '0;
         end
         if (mc_acc) begin
            mc_active = 1; mc_acc_cyc = cyc; mc_n = n_of(req_unit, req_func);
            mc_id = req_id; mc_res = {$urandom, $urandom};
         end
         if (capt) begin
            m_valid = 1; m_zero = 0; m_data = mc_res; m_id = mc_id; mc_active = 0;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         rst = 0; flush = 0; req_valid = 0; res_ready = 1;
         step();
      end
   endtask

   task automatic issue(input logic [1:0] unit, input logic [8:0] func, input logic [IDW-1:0] id,
                        input logic [XLEN-1:0] sc);
      req_valid = 1; req_unit = unit; req_func = func; req_id = id; sc_result = sc;
      step();
      req_valid = 0;
   endtask

   initial begin
      rst = 1; flush = 0; req_valid = 0; res_ready = 1; req_unit = '0; req_func = '0;
      req_id = '0; sc_result = '0; eng_result = '0;
      mc_active = 0; m_valid = 0; m_zero = 1; m_data = '0; m_id = '0; mc_acc_cyc = 0; mc_n = 1;
      repeat (2) @(posedge clk);
      #1;
      step();
      idle(1);

      // Back-to-back single-cycle ops.
      res_ready = 1;
      issue(2'd0, 9'd0, 3'd1, 64'hA);
      issue(2'd0, 9'd0, 3'd2, 64'hB);
      issue(2'd0, 9'd0, 3'd3, 64'hC);
      idle(2);

      // CLMUL full width, then CLMULW and the four CRC widths.
      issue(2'd1, 9'h000, 3'd4, 64'h0);
      idle(11);
      issue(2'd1, 9'h001, 3'd5, 64'h0);
      idle(7);
      for (int f = 0; f < 4; f++) begin
         issue(2'd2, 9'(f), 3'(f), 64'h0);
         idle(n_of(2'd2, 9'(f)) + 3);
      end

      // Reserved unit loads zero data.
      issue(2'd3, 9'h1ff, 3'd6, 64'hdead_beef);
      idle(2);

      // Backpressure: hold result, try to issue, then drain and refill together.
      issue(2'd0, 9'd0, 3'd7, 64'h55);
      res_ready = 0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_unit = 2'd0; req_id = 3'd2; sc_result = 64'h66;
         step();
      end
      res_ready = 1;
      step();
      req_valid = 0;
      idle(2);

      // Flush at step 3 of 8, then a clean op.
      issue(2'd1, 9'h000, 3'd1, 64'h0);
      idle(3);
      flush = 1; step(); flush = 0;
      idle(2);
      issue(2'd2, 9'h003, 3'd2, 64'h0);
      idle(12);

      // Reset mid-run.
      issue(2'd1, 9'h000, 3'd3, 64'h0);
      idle(4);
      rst = 1; step(); rst = 0;
      idle(3);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         flush     = !rst && ($urandom_range(0, 39) == 0);
         req_valid = ($urandom_range(0, 1) == 1);
         req_unit  = 2'($urandom_range(0, 3));
         req_func  = 9'($urandom);
         req_id    = IDW'($urandom);
         sc_result = {$urandom, $urandom};
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
